// File: rtl/knn_dict_cmp.sv
// kNN dictionary comparator: per scanner pixel, reads the image pixel, keeps the K
// nearest dictionary entries, casts one majority vote, and reports the window winner.
module knn_dict_cmp #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int ADDR_W    = 19,
    parameter int PIX_W     = 8,
    parameter int DICT_N    = 16,
    parameter int DICT_AW   = 4,
    parameter int K         = 3,
    parameter int NUM_CLASS = 4,
    parameter int CLS_W     = 2,
    parameter int CNT_W     = 8
) (
    input  logic               clk_en,
    input  logic               reset_n,
    input  logic               dic_go,
    input  logic               knn_fin,
    input  logic [9:0]         i,
    input  logic [9:0]         j,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic               pix_rd,
    input  logic [PIX_W-1:0]   pix_data,
    output logic [DICT_AW-1:0] dict_addr,
    input  logic [PIX_W-1:0]   dict_data,
    input  logic [CLS_W-1:0]   dict_label,
    output logic               dic_end,
    output logic               dic_end_q,
    output logic               result_valid,
    output logic [CLS_W-1:0]   result_class,
    output logic [CNT_W-1:0]   result_votes
);

    typedef enum logic [3:0] {
        S_IDLE, S_PIX_RD, S_PIX_WAIT, S_DICT, S_TAIL,
        S_CLASSIFY, S_END, S_GAP, S_VOTE, S_OUT
    } state_t;

    state_t             state_q;
    logic               go_prev_q;
    logic               in_range_q;
    logic [PIX_W-1:0]   pix_q;
    logic [DICT_AW-1:0] dict_addr_q;
    logic [PIX_W-1:0]   kd_q [K];
    logic [CLS_W-1:0]   kl_q [K];
    logic [CNT_W-1:0]   votes_q [NUM_CLASS];
    logic [CLS_W-1:0]   vcnt_q;
    logic [CLS_W-1:0]   best_cls_q;
    logic [CNT_W-1:0]   best_votes_q;
    logic               end_pulse_q;
    logic               end_dly_q;
    logic               result_valid_q;
    logic [CLS_W-1:0]   result_class_q;
    logic [CNT_W-1:0]   result_votes_q;

    logic               in_range_s;
    logic [PIX_W-1:0]   dist_s;
    logic               cmp_en_s;
    logic [K-1:0]       lt_s;
    logic [PIX_W-1:0]   kd_d [K];
    logic [CLS_W-1:0]   kl_d [K];
    logic [7:0]         tally_s [NUM_CLASS];
    logic [7:0]         maj_n_s;
    logic [CLS_W-1:0]   maj_s;
    logic               maj_take_s;
    logic [CNT_W-1:0]   cur_votes_s;
    logic               take_s;
    logic [CLS_W-1:0]   cand_cls_s;
    logic [CNT_W-1:0]   cand_votes_s;

    // Image RAM request; scanner underflow wraps i/j high, which lands out of range.
    always_comb begin
        in_range_s = (32'(i) < IMG_H) && (32'(j) < IMG_W);
        pix_rd     = 1'b0;
        pix_addr   = {ADDR_W{1'b0}};
        if ((state_q == S_PIX_RD) && in_range_s) begin
            pix_rd   = 1'b1;
            pix_addr = ADDR_W'(32'(i) * IMG_W + 32'(j));
        end else begin
            pix_rd   = 1'b0;
        end
    end

    // Distance and sorted insertion; strict less-than keeps earlier equal entries ahead.
    always_comb begin
        dist_s   = (pix_q >= dict_data) ? (pix_q - dict_data) : (dict_data - pix_q);
        cmp_en_s = ((state_q == S_DICT) && (dict_addr_q != {DICT_AW{1'b0}})) ||
                   (state_q == S_TAIL);
        for (int k = 0; k < K; k++) begin
            lt_s[k] = dist_s < kd_q[k];
            kd_d[k] = kd_q[k];
            kl_d[k] = kl_q[k];
        end
        kd_d[0] = lt_s[0] ? dist_s     : kd_q[0];
        kl_d[0] = lt_s[0] ? dict_label : kl_q[0];
        for (int k = 1; k < K; k++) begin
            if (lt_s[k-1]) begin
                kd_d[k] = kd_q[k-1];
                kl_d[k] = kl_q[k-1];
            end else if (lt_s[k]) begin
                kd_d[k] = dist_s;
                kl_d[k] = dict_label;
            end else begin
                kd_d[k] = kd_q[k];
                kl_d[k] = kl_q[k];
            end
        end
    end

    // Majority label over the K-best list, ties to the smaller label.
    always_comb begin
        for (int c = 0; c < NUM_CLASS; c++) tally_s[c] = 8'd0;
        for (int k = 0; k < K; k++) tally_s[kl_q[k]] = tally_s[kl_q[k]] + 8'd1;
        maj_s      = {CLS_W{1'b0}};
        maj_n_s    = tally_s[0];
        maj_take_s = 1'b0;
        for (int c = 1; c < NUM_CLASS; c++) begin
            maj_take_s = tally_s[c] > maj_n_s;
            maj_s      = maj_take_s ? CLS_W'(c) : maj_s;
            maj_n_s    = maj_take_s ? tally_s[c] : maj_n_s;
        end
    end

    // Running maximum over the vote counters during the VOTE scan.
    always_comb begin
        cur_votes_s  = votes_q[vcnt_q];
        take_s       = cur_votes_s > best_votes_q;
        cand_cls_s   = take_s ? vcnt_q      : best_cls_q;
        cand_votes_s = take_s ? cur_votes_s : best_votes_q;
    end

    // Main controller with registered pulse and result outputs.
    always_ff @(posedge clk_en) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            go_prev_q      <= 1'b0;
            in_range_q     <= 1'b0;
            pix_q          <= {PIX_W{1'b0}};
            dict_addr_q    <= {DICT_AW{1'b0}};
            vcnt_q         <= {CLS_W{1'b0}};
            best_cls_q     <= {CLS_W{1'b0}};
            best_votes_q   <= {CNT_W{1'b0}};
            end_pulse_q    <= 1'b0;
            end_dly_q      <= 1'b0;
            result_valid_q <= 1'b0;
            result_class_q <= {CLS_W{1'b0}};
            result_votes_q <= {CNT_W{1'b0}};
            for (int k = 0; k < K; k++) begin
                kd_q[k] <= {PIX_W{1'b0}};
                kl_q[k] <= {CLS_W{1'b0}};
            end
            for (int c = 0; c < NUM_CLASS; c++) votes_q[c] <= {CNT_W{1'b0}};
        end else begin
            go_prev_q      <= dic_go;
            end_pulse_q    <= 1'b0;
            end_dly_q      <= end_pulse_q;
            result_valid_q <= 1'b0;
            if (cmp_en_s) begin
                for (int k = 0; k < K; k++) begin
                    kd_q[k] <= kd_d[k];
                    kl_q[k] <= kl_d[k];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (dic_go && !go_prev_q) begin
                        for (int c = 0; c < NUM_CLASS; c++) votes_q[c] <= {CNT_W{1'b0}};
                        state_q <= S_PIX_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PIX_RD: begin
                    in_range_q <= in_range_s;
                    state_q    <= S_PIX_WAIT;
                end
                S_PIX_WAIT: begin
                    pix_q       <= pix_data;
                    dict_addr_q <= {DICT_AW{1'b0}};
                    for (int k = 0; k < K; k++) begin
                        kd_q[k] <= {PIX_W{1'b1}};
                        kl_q[k] <= {CLS_W{1'b0}};
                    end
                    state_q <= S_DICT;
                end
                S_DICT: begin
                    if (dict_addr_q == DICT_AW'(DICT_N - 1)) begin
                        state_q <= S_TAIL;
                    end else begin
                        dict_addr_q <= dict_addr_q + DICT_AW'(1);
                    end
                end
                S_TAIL: state_q <= S_CLASSIFY;
                S_CLASSIFY: begin
                    if (in_range_q && (votes_q[maj_s] != {CNT_W{1'b1}})) begin
                        votes_q[maj_s] <= votes_q[maj_s] + CNT_W'(1);
                    end
                    end_pulse_q <= 1'b1;
                    state_q     <= S_END;
                end
                S_END: state_q <= S_GAP;
                S_GAP: begin
                    if (knn_fin) begin
                        vcnt_q       <= {CLS_W{1'b0}};
                        best_cls_q   <= {CLS_W{1'b0}};
                        best_votes_q <= {CNT_W{1'b0}};
                        state_q      <= S_VOTE;
                    end else if (dic_go) begin
                        state_q <= S_PIX_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_VOTE: begin
                    best_cls_q   <= cand_cls_s;
                    best_votes_q <= cand_votes_s;
                    if (vcnt_q == CLS_W'(NUM_CLASS - 1)) begin
                        result_valid_q <= 1'b1;
                        result_class_q <= cand_cls_s;
                        result_votes_q <= cand_votes_s;
                        state_q        <= S_OUT;
                    end else begin
                        vcnt_q <= vcnt_q + CLS_W'(1);
                    end
                end
                S_OUT:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dict_addr    = dict_addr_q;
    assign dic_end      = end_pulse_q;
    assign dic_end_q    = end_dly_q;
    assign result_valid = result_valid_q;
    assign result_class = result_class_q;
    assign result_votes = result_votes_q;

endmodule
